// File: rtl/gold_bag_ctrl_if.sv
// Frame/terrain inputs and drawer-facing outputs of one gold bag.
// The master drives the frame and terrain inputs; the slave (the bag controller) drives position and status.
interface gold_bag_ctrl_if;
    logic               startOfFrame;
    logic               collision;
    logic               side;
    logic               can_fall;
    logic               been_eaten;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         bag_state;
    logic [1:0]         image;
    logic               moving;
    logic               lethal;

    modport master (
        output startOfFrame, collision, side, can_fall, been_eaten,
        input  topLeftX, topLeftY, bag_state, image, moving, lethal
    );

    modport slave (
        input  startOfFrame, collision, side, can_fall, been_eaten,
        output topLeftX, topLeftY, bag_state, image, moving, lethal
    );
endinterface

// File: rtl/gold_bag_ctrl.sv
// Gold-bag movement controller: push, wobble, fall, crash and eaten for one bag.
// Position is kept in fixed-point accumulators that only advance on startOfFrame.
module gold_bag_ctrl #(
    parameter int INITIAL_X         = 32,
    parameter int INITIAL_Y         = 160,
    parameter int CELL_LOG2         = 5,
    parameter int FRAC_BITS         = 6,
    parameter int X_SPEED           = 128,
    parameter int Y_SPEED           = 128,
    parameter int WOBBLE_FRAMES     = 25,
    parameter int WOBBLE_PHASE_LOG2 = 3,
    parameter int CRASH_ROWS        = 2,
    parameter int X_MIN             = 0,
    parameter int X_MAX             = 608
) (
    input  logic           clk,
    input  logic           resetN,
    gold_bag_ctrl_if.slave bag
);

    localparam int                 WCW      = $clog2(WOBBLE_FRAMES + 1);
    localparam logic [WCW-1:0]     WOB_MAX  = WCW'(WOBBLE_FRAMES);
    localparam logic signed [31:0] ACC_X0   = 32'(INITIAL_X) << FRAC_BITS;
    localparam logic signed [31:0] ACC_Y0   = 32'(INITIAL_Y) << FRAC_BITS;
    localparam logic signed [31:0] XSPD     = 32'(X_SPEED);
    localparam logic signed [31:0] YSPD     = 32'(Y_SPEED);
    localparam logic signed [10:0] X_MIN_C  = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_C  = 11'(X_MAX);
    localparam logic [3:0]         CRASH_C  = 4'(CRASH_ROWS);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_START,
        PUSHING,
        WOBBLE,
        FALLING,
        CRASHED,
        EATEN
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] acc_x_q, acc_x_d;
    logic signed [31:0] acc_y_q, acc_y_d;
    logic [WCW-1:0]     wob_q, wob_d;
    logic [3:0]         rows_q, rows_d;
    logic               latch_q, latch_d;
    logic               dir_q, dir_d;

    logic signed [31:0] x_speed, y_speed, acc_y_next;
    logic signed [10:0] pos_x, pos_y, next_y;
    logic               aligned_x, aligned_y, next_aligned_y;
    logic               push_ok, wob_active;
    logic [1:0]         wob_phase;
    logic [1:0]         bag_state, image;
    logic               moving, lethal;

    assign pos_x          = acc_x_q[FRAC_BITS+10:FRAC_BITS];
    assign pos_y          = acc_y_q[FRAC_BITS+10:FRAC_BITS];
    assign acc_y_next     = acc_y_q + y_speed;
    assign next_y         = acc_y_next[FRAC_BITS+10:FRAC_BITS];
    assign aligned_x      = (pos_x[CELL_LOG2-1:0] == '0);
    assign aligned_y      = (pos_y[CELL_LOG2-1:0] == '0);
    assign next_aligned_y = (next_y[CELL_LOG2-1:0] == '0);
    // side = 1 means the digger came from the right, so the bag moves left.
    assign push_ok        = bag.side ? (pos_x > X_MIN_C) : (pos_x < X_MAX_C);
    assign wob_active     = (wob_q < WOB_MAX);
    assign wob_phase      = 2'(wob_q >> WOBBLE_PHASE_LOG2);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            acc_x_q <= ACC_X0;
            acc_y_q <= ACC_Y0;
            wob_q   <= '0;
            rows_q  <= '0;
            latch_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            wob_q   <= wob_d;
            rows_q  <= rows_d;
            latch_q <= latch_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (latch_q && push_ok) begin
                    state_d = PUSH_START;
                    dir_d   = bag.side;
                end else if (bag.can_fall) begin
                    state_d = WOBBLE;
                end
            end
            PUSH_START: if (!aligned_x) state_d = PUSHING;
            PUSHING: begin
                if (aligned_x) state_d = bag.can_fall ? WOBBLE : IDLE;
            end
            WOBBLE: begin
                if (wob_active) begin
                    if (latch_q && push_ok) begin
                        state_d = PUSH_START;
                        dir_d   = bag.side;
                    end
                end else if (!aligned_y) begin
                    state_d = FALLING;
                end
            end
            FALLING: begin
                if (aligned_y && !bag.can_fall) state_d = (rows_q >= CRASH_C) ? CRASHED : IDLE;
            end
            CRASHED: if (bag.been_eaten) state_d = EATEN;
            EATEN:   state_d = EATEN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_speed   = '0;
        y_speed   = '0;
        bag_state = 2'd0;
        image     = 2'd0;
        moving    = 1'b0;
        lethal    = 1'b0;
        case (state_q)
            PUSH_START: begin
                moving  = 1'b1;
                x_speed = dir_q ? -XSPD : XSPD;
            end
            PUSHING: begin
                moving = 1'b1;
                if (!aligned_x) x_speed = dir_q ? -XSPD : XSPD;
            end
            WOBBLE: begin
                if (wob_active) begin
                    case (wob_phase)
                        2'd1:    image = 2'd1;
                        2'd3:    image = 2'd2;
                        default: image = 2'd0;
                    endcase
                end else begin
                    y_speed = YSPD;
                end
            end
            FALLING: begin
                bag_state = 2'd1;
                lethal    = 1'b1;
                if (!(aligned_y && !bag.can_fall)) y_speed = YSPD;
            end
            CRASHED: begin
                bag_state = 2'd2;
                image     = 2'd3;
            end
            EATEN:   bag_state = 2'd3;
            default: ;
        endcase
    end

    // Counters outside WOBBLE clear on every frame so a fresh wobble always starts at zero.
    always_comb begin
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        wob_d   = wob_q;
        rows_d  = rows_q;
        latch_d = bag.startOfFrame ? 1'b0 : (latch_q | bag.collision);
        if (bag.startOfFrame) begin
            acc_x_d = acc_x_q + x_speed;
            acc_y_d = acc_y_next;
            if (state_q == WOBBLE) begin
                if (wob_active) wob_d = wob_q + WCW'(1);
                rows_d = '0;
            end else begin
                wob_d = '0;
            end
            if (state_q == FALLING && y_speed != 0 && next_aligned_y && rows_q != 4'hF) begin
                rows_d = rows_q + 4'd1;
            end
        end
    end

    assign bag.topLeftX  = pos_x;
    assign bag.topLeftY  = pos_y;
    assign bag.bag_state = bag_state;
    assign bag.image     = image;
    assign bag.moving    = moving;
    assign bag.lethal    = lethal;

endmodule

// File: tb/tb_gold_bag_ctrl.sv
// Scoreboard bench for gold_bag_ctrl: a per-frame behavioural model queues expected
// outputs and an independent monitor compares them with the DUT after each frame.
module tb_gold_bag_ctrl;

    localparam int INITIAL_X         = 32;
    localparam int INITIAL_Y         = 160;
    localparam int CELL_LOG2         = 5;
    localparam int FRAC_BITS         = 6;
    localparam int X_SPEED           = 128;
    localparam int Y_SPEED           = 128;
    localparam int WOBBLE_FRAMES     = 25;
    localparam int WOBBLE_PHASE_LOG2 = 3;
    localparam int CRASH_ROWS        = 2;
    localparam int X_MIN             = 0;
    localparam int X_MAX             = 128;

    localparam int CELL   = 1 << CELL_LOG2;
    localparam int STEP_X = X_SPEED / (1 << FRAC_BITS);
    localparam int STEP_Y = Y_SPEED / (1 << FRAC_BITS);

    typedef struct packed {
        logic signed [10:0] x;
        logic signed [10:0] y;
        logic [1:0]         st;
        logic [1:0]         img;
        logic               mv;
        logic               lt;
    } obs_t;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    gold_bag_ctrl_if bag();

    gold_bag_ctrl #(
        .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y), .CELL_LOG2(CELL_LOG2),
        .FRAC_BITS(FRAC_BITS), .X_SPEED(X_SPEED), .Y_SPEED(Y_SPEED),
        .WOBBLE_FRAMES(WOBBLE_FRAMES), .WOBBLE_PHASE_LOG2(WOBBLE_PHASE_LOG2),
        .CRASH_ROWS(CRASH_ROWS), .X_MIN(X_MIN), .X_MAX(X_MAX)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bag(bag)
    );

    obs_t  expQ[$];
    string tagQ[$];
    event  sampleEv;
    int    nCompared   = 0;
    int    nMismatched = 0;

    // Behavioural model of the bag, in whole pixels and plain flags.
    int mX, mY, mDir, mWobble, mRows;
    bit mPushing, mFalling, mCrashed, mEaten, mLatch;

    task automatic modelReset();
        mX = INITIAL_X; mY = INITIAL_Y; mDir = 0; mWobble = -1; mRows = 0;
        mPushing = 0; mFalling = 0; mCrashed = 0; mEaten = 0; mLatch = 0;
    endtask

    function automatic bit isResting();
        return !mPushing && mWobble < 0 && !mFalling && !mCrashed && !mEaten;
    endfunction

    function automatic bit pushLegal(input bit sd);
        return sd ? (mX > X_MIN) : (mX < X_MAX);
    endfunction

    task automatic startPush(input bit sd);
        mPushing = 1;
        mDir     = sd ? -1 : 1;
        mWobble  = -1;
    endtask

    function automatic logic [1:0] wobImage(input int cnt);
        int ph;
        ph = (cnt / (1 << WOBBLE_PHASE_LOG2)) % 4;
        if (ph == 1) return 2'd1;
        if (ph == 3) return 2'd2;
        return 2'd0;
    endfunction

    // Reactions that happen between frames, repeated until nothing changes.
    task automatic modelSettle(input bit sd, input bit cf, input bit eat);
        for (int i = 0; i < 4; i++) begin
            if (mFalling && (mY % CELL == 0) && !cf) begin
                mFalling = 0;
                mCrashed = (mRows >= CRASH_ROWS);
            end else if (mCrashed && eat) begin
                mCrashed = 0;
                mEaten   = 1;
            end else if (isResting()) begin
                if (mLatch && pushLegal(sd)) startPush(sd);
                else if (cf) mWobble = 0;
            end else if (mWobble >= 0 && mWobble < WOBBLE_FRAMES && mLatch && pushLegal(sd)) begin
                startPush(sd);
            end
        end
    endtask

    task automatic modelFrame();
        mLatch = 0;
        if (mPushing) begin
            mX = mX + mDir * STEP_X;
            if (mX % CELL == 0) mPushing = 0;
        end else if (mWobble >= 0) begin
            if (mWobble >= WOBBLE_FRAMES) mY = mY + STEP_Y;
            if (mWobble < WOBBLE_FRAMES) mWobble++;
            mRows = 0;
            if (mY % CELL != 0) begin
                mWobble  = -1;
                mFalling = 1;
            end
        end else if (mFalling) begin
            mY = mY + STEP_Y;
            if (mY % CELL == 0 && mRows < 15) mRows++;
        end
    endtask

    task automatic checkOutput(input string tag);
        obs_t e;
        e.x   = 11'(mX);
        e.y   = 11'(mY);
        e.st  = mFalling ? 2'd1 : mCrashed ? 2'd2 : mEaten ? 2'd3 : 2'd0;
        e.img = mCrashed ? 2'd3 :
                (mWobble >= 0 && mWobble < WOBBLE_FRAMES) ? wobImage(mWobble) : 2'd0;
        e.mv  = mPushing;
        e.lt  = mFalling;
        expQ.push_back(e);
        tagQ.push_back(tag);
        ->sampleEv;
    endtask

    // One frame: optional collision pulse, settle, startOfFrame, settle, then queue a check.
    task automatic applyStimulus(input bit coll, input bit sd, input bit cf, input bit eat,
                                 input string tag);
        bag.side       = sd;
        bag.can_fall   = cf;
        bag.been_eaten = eat;
        if (coll) begin
            bag.collision = 1'b1;
            mLatch        = 1;
        end
        @(negedge clk);
        bag.collision = 1'b0;
        repeat (3) @(negedge clk);
        modelSettle(sd, cf, eat);
        bag.startOfFrame = 1'b1;
        @(negedge clk);
        bag.startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
        modelFrame();
        modelSettle(sd, cf, eat);
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        bag.collision = 1'b0; bag.startOfFrame = 1'b0; bag.can_fall = 1'b0;
        bag.been_eaten = 1'b0; bag.side = 1'b0;
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        checkOutput(tag);
        resetN = 1'b1;
    endtask

    initial begin
        obs_t  act;
        obs_t  expO;
        string tag;
        forever begin
            @(sampleEv);
            act.x   = bag.topLeftX;
            act.y   = bag.topLeftY;
            act.st  = bag.bag_state;
            act.img = bag.image;
            act.mv  = bag.moving;
            act.lt  = bag.lethal;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL unexpected_sample: got x=%0d y=%0d, nothing expected", act.x, act.y);
            end else begin
                expO = expQ.pop_front();
                tag  = tagQ.pop_front();
                if (act !== expO) begin
                    nMismatched++;
                    $display("[TB] FAIL %s: got x=%0d y=%0d st=%0d img=%0d mv=%0b lt=%0b, want x=%0d y=%0d st=%0d img=%0d mv=%0b lt=%0b",
                             tag, act.x, act.y, act.st, act.img, act.mv, act.lt,
                             expO.x, expO.y, expO.st, expO.img, expO.mv, expO.lt);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g;
        bit cf;
        resetN = 1'b0;
        bag.collision = 1'b0; bag.startOfFrame = 1'b0; bag.side = 1'b0;
        bag.can_fall = 1'b0; bag.been_eaten = 1'b0;
        repeat (3) @(negedge clk);
        modelReset();
        checkOutput("reset");
        resetN = 1'b1;

        // Push right one cell on flat ground.
        applyStimulus(1, 0, 0, 0, "push_right");
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, "push_right_step");

        // Wobble, fall one row, then land.
        g = 0;
        while (mY != INITIAL_Y + CELL && g < 200) begin
            applyStimulus(0, 0, 1, 0, "wobble_fall");
            g++;
        end
        applyStimulus(0, 0, 0, 0, "land_one_row");

        // Fall two rows, crash, get eaten, stay eaten.
        g = 0;
        while (mY != INITIAL_Y + 3 * CELL && g < 200) begin
            applyStimulus(0, 0, 1, 0, "fall_two_rows");
            g++;
        end
        applyStimulus(0, 0, 0, 0, "crash");
        applyStimulus(0, 0, 0, 0, "crashed_hold");
        applyStimulus(0, 0, 0, 1, "eaten");
        applyStimulus(1, 0, 1, 0, "eaten_terminal");

        // Left limit, push-beats-fall, right limit.
        doReset("reset2");
        applyStimulus(1, 1, 0, 0, "push_left");
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, "push_left_step");
        applyStimulus(1, 1, 0, 0, "blocked_at_xmin");
        applyStimulus(1, 0, 1, 0, "push_wins_over_fall");
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, "push_step");
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1, 0, 0, 0, "push_to_xmax");
            for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 0, "push_to_xmax_step");
        end
        applyStimulus(1, 0, 0, 0, "blocked_at_xmax");

        // Push during wobble cancels the fall; wobble restarts afterwards.
        g = 0;
        while (mWobble != 10 && g < 50) begin
            applyStimulus(0, 1, 1, 0, "wobble_to_10");
            g++;
        end
        applyStimulus(1, 1, 1, 0, "push_in_wobble");
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 0, "rewobble");

        // Asynchronous reset in the middle of a push.
        doReset("reset3");
        applyStimulus(1, 0, 0, 0, "push_before_reset");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, "push_before_reset_step");
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 modelReset();
        checkOutput("mid_push_reset");
        @(negedge clk);
        resetN = 1'b1;

        // Randomized episodes.
        for (int ep = 0; ep < 5; ep++) begin
            doReset("reset_rand");
            cf = 1'b0;
            for (int f = 0; f < 160; f++) begin
                if ($urandom_range(7) == 0) cf = ~cf;
                applyStimulus($urandom_range(5) == 0, 1'($urandom_range(1)), cf,
                              $urandom_range(3) == 0, "random");
            end
        end

        repeat (4) @(negedge clk);
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL pending_checks: got %0d unchecked, want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
